// File: rtl/pipeline_stall_ctrl_pkg.sv
// Shared constants for the pipeline stall/flush sequencer: bypass codes,
// stall-cause encoding, divider FSM states and the per-side hazard helper.
package pipeline_stall_ctrl_pkg;

    localparam logic [2:0] FWD_RF   = 3'b000;
    localparam logic [2:0] FWD_EXE  = 3'b001;
    localparam logic [2:0] FWD_MEM  = 3'b010;
    localparam logic [2:0] FWD_MEM2 = 3'b011;
    localparam logic [2:0] FWD_WB   = 3'b100;

    typedef enum logic [1:0] {
        STALL_NONE = 2'b00,
        STALL_LU   = 2'b01,
        STALL_DIV  = 2'b10,
        STALL_MEM  = 2'b11
    } stall_cause_t;

    localparam logic [1:0] DIV_IDLE = 2'd0;
    localparam logic [1:0] DIV_RUN  = 2'd1;
    localparam logic [1:0] DIV_DONE = 2'd2;

    // A bypass source is hazardous only if it is selected, used, and not yet ready.
    function automatic logic side_hazard(
        input logic       use_reg,
        input logic [2:0] fwd,
        input logic       exe_rdy,
        input logic       mem_rdy,
        input logic       mem2_rdy
    );
        logic haz;
        case (fwd)
            FWD_EXE:        haz = !exe_rdy;
            FWD_MEM:        haz = !mem_rdy;
            FWD_MEM2:       haz = !mem2_rdy;
            FWD_RF, FWD_WB: haz = 1'b0;
            default:        haz = 1'b0;
        endcase
        return use_reg && haz;
    endfunction

endpackage

// File: rtl/pipeline_stall_ctrl_loaduse_detect.sv
// Load-use hazard detect: ID needs a bypassed operand whose producer has no
// data yet.
module pipeline_stall_ctrl_loaduse_detect
    import pipeline_stall_ctrl_pkg::*;
(
    input  logic [2:0] fwd_a,
    input  logic [2:0] fwd_b,
    input  logic       use_rs,
    input  logic       use_rt,
    input  logic       exe_rdy,
    input  logic       mem_rdy,
    input  logic       mem2_rdy,
    output logic       lu_c
);

    logic haz_a_c;
    logic haz_b_c;

    assign haz_a_c = side_hazard(use_rs, fwd_a, exe_rdy, mem_rdy, mem2_rdy);
    assign haz_b_c = side_hazard(use_rt, fwd_b, exe_rdy, mem_rdy, mem2_rdy);
    assign lu_c    = haz_a_c | haz_b_c;

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Central stall/flush sequencer for the IF/ID/EXE/MEM/MEM2/WB pipeline,
// including the multi-cycle divider sequencing FSM.
module pipeline_stall_ctrl
    import pipeline_stall_ctrl_pkg::*;
#(
    parameter int unsigned DIV_LAT = 32,
    parameter int unsigned CNT_W   = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] ID_ForwardA,
    input  logic [2:0] ID_ForwardB,
    input  logic       ID_UseRs,
    input  logic       ID_UseRt,
    input  logic       EXE_DataRdy,
    input  logic       MEM_DataRdy,
    input  logic       MEM2_DataRdy,
    input  logic       EXE_IsDiv,
    input  logic       ICache_Busy,
    input  logic       DCache_Busy,
    input  logic       EXE_BranchFlush,
    input  logic       WB_ExcFlush,
    output logic       PC_Wr,
    output logic       IF_ID_Wr,
    output logic       ID_EXE_Wr,
    output logic       EXE_MEM_Wr,
    output logic       MEM_MEM2_Wr,
    output logic       MEM2_WB_Wr,
    output logic       IF_ID_Flush,
    output logic       ID_EXE_Flush,
    output logic       EXE_MEM_Flush,
    output logic       MEM_MEM2_Flush,
    output logic       MEM2_WB_Flush,
    output logic       Div_Start,
    output logic [1:0] Stall_Cause
);

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             lu_c;
    logic             div_start_c;
    logic             div_stall_c;
    stall_cause_t     cause;

    pipeline_stall_ctrl_loaduse_detect u_lu (
        .fwd_a    (ID_ForwardA),
        .fwd_b    (ID_ForwardB),
        .use_rs   (ID_UseRs),
        .use_rt   (ID_UseRt),
        .exe_rdy  (EXE_DataRdy),
        .mem_rdy  (MEM_DataRdy),
        .mem2_rdy (MEM2_DataRdy),
        .lu_c     (lu_c)
    );

    // A divide may only launch from IDLE and never while the D-cache freezes EXE.
    assign div_start_c = !rst && !WB_ExcFlush && !DCache_Busy && EXE_IsDiv
                         && (state == DIV_IDLE);
    assign div_stall_c = div_start_c || (state == DIV_RUN);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= DIV_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Divider next state plus all pipeline-control decisions, in priority order.
    always_comb begin
        state_nxt      = state;
        cnt_nxt        = cnt;
        PC_Wr          = 1'b1;
        IF_ID_Wr       = 1'b1;
        ID_EXE_Wr      = 1'b1;
        EXE_MEM_Wr     = 1'b1;
        MEM_MEM2_Wr    = 1'b1;
        MEM2_WB_Wr     = 1'b1;
        IF_ID_Flush    = 1'b0;
        ID_EXE_Flush   = 1'b0;
        EXE_MEM_Flush  = 1'b0;
        MEM_MEM2_Flush = 1'b0;
        MEM2_WB_Flush  = 1'b0;
        Div_Start      = 1'b0;
        cause          = STALL_NONE;

        if (WB_ExcFlush) begin
            state_nxt = DIV_IDLE;
            cnt_nxt   = '0;
        end else begin
            case (state)
                DIV_IDLE: begin
                    if (div_start_c) begin
                        state_nxt = DIV_RUN;
                        cnt_nxt   = CNT_W'(DIV_LAT);
                    end
                end
                // Counter keeps running under a D-cache freeze.
                DIV_RUN: begin
                    cnt_nxt = cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        state_nxt = DIV_DONE;
                    end
                end
                DIV_DONE: state_nxt = DIV_IDLE;
                default: begin
                    state_nxt = DIV_IDLE;
                    cnt_nxt   = '0;
                end
            endcase
        end

        if (rst) begin
            PC_Wr          = 1'b0;
            IF_ID_Wr       = 1'b0;
            ID_EXE_Wr      = 1'b0;
            EXE_MEM_Wr     = 1'b0;
            MEM_MEM2_Wr    = 1'b0;
            MEM2_WB_Wr     = 1'b0;
            IF_ID_Flush    = 1'b1;
            ID_EXE_Flush   = 1'b1;
            EXE_MEM_Flush  = 1'b1;
            MEM_MEM2_Flush = 1'b1;
            MEM2_WB_Flush  = 1'b1;
        end else if (WB_ExcFlush) begin
            PC_Wr          = 1'b1;
            IF_ID_Flush    = 1'b1;
            ID_EXE_Flush   = 1'b1;
            EXE_MEM_Flush  = 1'b1;
            MEM_MEM2_Flush = 1'b1;
            MEM2_WB_Flush  = 1'b1;
        end else if (DCache_Busy) begin
            PC_Wr       = 1'b0;
            IF_ID_Wr    = 1'b0;
            ID_EXE_Wr   = 1'b0;
            EXE_MEM_Wr  = 1'b0;
            MEM_MEM2_Wr = 1'b0;
            MEM2_WB_Wr  = 1'b0;
            cause       = STALL_MEM;
        end else if (div_stall_c) begin
            PC_Wr         = 1'b0;
            IF_ID_Wr      = 1'b0;
            ID_EXE_Wr     = 1'b0;
            EXE_MEM_Wr    = 1'b0;
            EXE_MEM_Flush = 1'b1;
            Div_Start     = div_start_c;
            cause         = STALL_DIV;
        end else begin
            if (lu_c) begin
                PC_Wr        = 1'b0;
                IF_ID_Wr     = 1'b0;
                ID_EXE_Flush = 1'b1;
                cause        = STALL_LU;
            end
            if (ICache_Busy) begin
                PC_Wr = 1'b0;
                if (!lu_c) begin
                    IF_ID_Flush = 1'b1;
                    cause       = STALL_MEM;
                end
            end
            // Redirect wins for the PC; a held ID keeps its delay slot.
            if (EXE_BranchFlush) begin
                PC_Wr = 1'b1;
                if (!lu_c) begin
                    IF_ID_Flush = 1'b1;
                end
            end
        end

        Stall_Cause = cause;
    end

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Scoreboard bench for pipeline_stall_ctrl: two instances (DIV_LAT=4 and 8)
// share stimulus; directed vectors queue expected outputs for a monitor.
module tb_pipeline_stall_ctrl;

    typedef struct {
        int         vec;
        int         sel;
        logic [5:0] wr;
        logic [5:0] wr_m;
        logic [4:0] fl;
        logic [4:0] fl_m;
        logic       ds;
        logic       ds_m;
        logic [1:0] cs;
        logic [1:0] cs_m;
    } exp_t;

    localparam logic [5:0] W_ALL  = 6'b111111;
    localparam logic [5:0] W_NONE = 6'b000000;
    localparam logic [5:0] W_LU   = 6'b001111;
    localparam logic [5:0] W_DIV  = 6'b000011;
    localparam logic [5:0] W_IC   = 6'b011111;
    localparam logic [5:0] W_BRLU = 6'b101111;
    localparam logic [4:0] F_ALL  = 5'b11111;
    localparam logic [4:0] F_NONE = 5'b00000;
    localparam logic [4:0] F_IFID = 5'b10000;
    localparam logic [4:0] F_IDEX = 5'b01000;
    localparam logic [4:0] F_EXMM = 5'b00100;

    logic       clk;
    logic       rst;
    logic [2:0] fwd_a;
    logic [2:0] fwd_b;
    logic       use_rs;
    logic       use_rt;
    logic       exe_rdy;
    logic       mem_rdy;
    logic       mem2_rdy;
    logic       exe_is_div;
    logic       icache_busy;
    logic       dcache_busy;
    logic       br_flush;
    logic       exc_flush;

    logic [5:0] wr4, wr8;
    logic [4:0] fl4, fl8;
    logic       ds4, ds8;
    logic [1:0] cs4, cs8;

    exp_t exp_q[$];
    int   checks;
    int   failures;
    int   vec;

    pipeline_stall_ctrl #(.DIV_LAT(4), .CNT_W(6)) u_dut4 (
        .clk(clk), .rst(rst),
        .ID_ForwardA(fwd_a), .ID_ForwardB(fwd_b),
        .ID_UseRs(use_rs), .ID_UseRt(use_rt),
        .EXE_DataRdy(exe_rdy), .MEM_DataRdy(mem_rdy), .MEM2_DataRdy(mem2_rdy),
        .EXE_IsDiv(exe_is_div), .ICache_Busy(icache_busy), .DCache_Busy(dcache_busy),
        .EXE_BranchFlush(br_flush), .WB_ExcFlush(exc_flush),
        .PC_Wr(wr4[5]), .IF_ID_Wr(wr4[4]), .ID_EXE_Wr(wr4[3]),
        .EXE_MEM_Wr(wr4[2]), .MEM_MEM2_Wr(wr4[1]), .MEM2_WB_Wr(wr4[0]),
        .IF_ID_Flush(fl4[4]), .ID_EXE_Flush(fl4[3]), .EXE_MEM_Flush(fl4[2]),
        .MEM_MEM2_Flush(fl4[1]), .MEM2_WB_Flush(fl4[0]),
        .Div_Start(ds4), .Stall_Cause(cs4)
    );

    pipeline_stall_ctrl #(.DIV_LAT(8), .CNT_W(6)) u_dut8 (
        .clk(clk), .rst(rst),
        .ID_ForwardA(fwd_a), .ID_ForwardB(fwd_b),
        .ID_UseRs(use_rs), .ID_UseRt(use_rt),
        .EXE_DataRdy(exe_rdy), .MEM_DataRdy(mem_rdy), .MEM2_DataRdy(mem2_rdy),
        .EXE_IsDiv(exe_is_div), .ICache_Busy(icache_busy), .DCache_Busy(dcache_busy),
        .EXE_BranchFlush(br_flush), .WB_ExcFlush(exc_flush),
        .PC_Wr(wr8[5]), .IF_ID_Wr(wr8[4]), .ID_EXE_Wr(wr8[3]),
        .EXE_MEM_Wr(wr8[2]), .MEM_MEM2_Wr(wr8[1]), .MEM2_WB_Wr(wr8[0]),
        .IF_ID_Flush(fl8[4]), .ID_EXE_Flush(fl8[3]), .EXE_MEM_Flush(fl8[2]),
        .MEM_MEM2_Flush(fl8[1]), .MEM2_WB_Flush(fl8[0]),
        .Div_Start(ds8), .Stall_Cause(cs8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // sel: 0 = DIV_LAT 4 instance, 1 = DIV_LAT 8 instance, 2 = both
    task automatic push(input int sel,
                        input logic [5:0] wr, input logic [5:0] wr_m,
                        input logic [4:0] fl, input logic [4:0] fl_m,
                        input logic ds, input logic ds_m,
                        input logic [1:0] cs, input logic [1:0] cs_m);
        exp_t e;
        vec++;
        e.vec = vec; e.wr = wr; e.wr_m = wr_m; e.fl = fl; e.fl_m = fl_m;
        e.ds = ds; e.ds_m = ds_m; e.cs = cs; e.cs_m = cs_m;
        if (sel == 2) begin
            e.sel = 0; exp_q.push_back(e);
            e.sel = 1; exp_q.push_back(e);
        end else begin
            e.sel = sel; exp_q.push_back(e);
        end
    endtask

    task automatic expect_all(input int sel, input logic [5:0] wr, input logic [4:0] fl,
                              input logic ds, input logic [1:0] cs);
        push(sel, wr, W_ALL, fl, F_ALL, ds, 1'b1, cs, 2'b11);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        fwd_a = 3'b000; fwd_b = 3'b000; use_rs = 1'b0; use_rt = 1'b0;
        exe_rdy = 1'b1; mem_rdy = 1'b1; mem2_rdy = 1'b1;
        exe_is_div = 1'b0; icache_busy = 1'b0; dcache_busy = 1'b0;
        br_flush = 1'b0; exc_flush = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        tick();
        expect_all(2, W_NONE, F_ALL, 1'b0, 2'b00);
        tick();
        rst = 1'b0;
    endtask

    // Monitor: the control outputs are valid every cycle, so drain all queued
    // expectations at the falling edge of the cycle they were issued in.
    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            exp_t       e;
            logic [5:0] a_wr;
            logic [4:0] a_fl;
            logic       a_ds;
            logic [1:0] a_cs;
            e = exp_q.pop_front();
            a_wr = (e.sel == 0) ? wr4 : wr8;
            a_fl = (e.sel == 0) ? fl4 : fl8;
            a_ds = (e.sel == 0) ? ds4 : ds8;
            a_cs = (e.sel == 0) ? cs4 : cs8;
            if (e.wr_m != 6'b0) begin
                checks++;
                if ((a_wr & e.wr_m) != (e.wr & e.wr_m)) begin
                    failures++;
                    $display("FAIL v%0d.dut%0d wr: got %b want %b (mask %b)",
                             e.vec, e.sel, a_wr, e.wr, e.wr_m);
                end
            end
            if (e.fl_m != 5'b0) begin
                checks++;
                if ((a_fl & e.fl_m) != (e.fl & e.fl_m)) begin
                    failures++;
                    $display("FAIL v%0d.dut%0d flush: got %b want %b (mask %b)",
                             e.vec, e.sel, a_fl, e.fl, e.fl_m);
                end
            end
            if (e.ds_m) begin
                checks++;
                if (a_ds != e.ds) begin
                    failures++;
                    $display("FAIL v%0d.dut%0d div_start: got %b want %b",
                             e.vec, e.sel, a_ds, e.ds);
                end
            end
            if (e.cs_m != 2'b0) begin
                checks++;
                if ((a_cs & e.cs_m) != (e.cs & e.cs_m)) begin
                    failures++;
                    $display("FAIL v%0d.dut%0d stall_cause: got %b want %b",
                             e.vec, e.sel, a_cs, e.cs);
                end
            end
        end
    end

    initial begin
        checks = 0; failures = 0; vec = 0;
        clear_inputs();
        rst = 1'b1;
        #1;

        // Reset state, then idle defaults.
        do_reset();
        expect_all(2, W_ALL, F_NONE, 1'b0, 2'b00);
        tick();

        // Load-use on side A from EXE, then resolved via ready MEM source.
        fwd_a = 3'b001; use_rs = 1'b1; exe_rdy = 1'b0;
        expect_all(2, W_LU, F_IDEX, 1'b0, 2'b01);
        tick();
        fwd_a = 3'b010; mem_rdy = 1'b1; exe_rdy = 1'b1;
        expect_all(2, W_ALL, F_NONE, 1'b0, 2'b00);
        tick();
        // Side B from MEM2 not ready.
        clear_inputs();
        fwd_b = 3'b011; use_rt = 1'b1; mem2_rdy = 1'b0;
        expect_all(2, W_LU, F_IDEX, 1'b0, 2'b01);
        tick();
        // Same source but rt not read: no hazard.
        use_rt = 1'b0;
        expect_all(2, W_ALL, F_NONE, 1'b0, 2'b00);
        tick();
        // WB and RF sources never stall, even with all ready flags low.
        clear_inputs();
        fwd_a = 3'b100; fwd_b = 3'b000; use_rs = 1'b1; use_rt = 1'b1;
        exe_rdy = 1'b0; mem_rdy = 1'b0; mem2_rdy = 1'b0;
        expect_all(2, W_ALL, F_NONE, 1'b0, 2'b00);
        tick();

        // Branch alone, branch with load-use, I-cache alone, I-cache with load-use.
        clear_inputs();
        br_flush = 1'b1;
        expect_all(2, W_ALL, F_IFID, 1'b0, 2'b00);
        tick();
        fwd_a = 3'b001; use_rs = 1'b1; exe_rdy = 1'b0;
        expect_all(2, W_BRLU, F_IDEX, 1'b0, 2'b01);
        tick();
        clear_inputs();
        icache_busy = 1'b1;
        push(2, W_IC, W_ALL, F_IFID, F_ALL, 1'b0, 1'b1, 2'b00, 2'b00);
        tick();
        fwd_a = 3'b001; use_rs = 1'b1; exe_rdy = 1'b0;
        expect_all(2, W_LU, F_IDEX, 1'b0, 2'b01);
        tick();

        // Divide, DIV_LAT=4: five stall cycles, DONE ignores the held EXE_IsDiv.
        do_reset();
        exe_is_div = 1'b1;
        expect_all(0, W_DIV, F_EXMM, 1'b1, 2'b10);
        tick();
        for (int i = 0; i < 4; i++) begin
            expect_all(0, W_DIV, F_EXMM, 1'b0, 2'b10);
            tick();
        end
        expect_all(0, W_ALL, F_NONE, 1'b0, 2'b00);
        tick();
        exe_is_div = 1'b0;
        expect_all(0, W_ALL, F_NONE, 1'b0, 2'b00);
        tick();

        // Divide, DIV_LAT=8, D-cache freeze in cycles 3..5 does not stretch it.
        do_reset();
        exe_is_div = 1'b1;
        for (int c = 0; c < 10; c++) begin
            dcache_busy = (c >= 3 && c <= 5);
            if (c == 0)
                expect_all(1, W_DIV, F_EXMM, 1'b1, 2'b10);
            else if (c >= 3 && c <= 5)
                expect_all(1, W_NONE, F_NONE, 1'b0, 2'b11);
            else if (c <= 8)
                expect_all(1, W_DIV, F_EXMM, 1'b0, 2'b10);
            else
                expect_all(1, W_ALL, F_NONE, 1'b0, 2'b00);
            tick();
        end
        clear_inputs();
        expect_all(1, W_ALL, F_NONE, 1'b0, 2'b00);
        tick();

        // Exception mid-divide under D-cache freeze aborts; IDLE may restart next cycle.
        do_reset();
        exe_is_div = 1'b1;
        tick();
        expect_all(2, W_DIV, F_EXMM, 1'b0, 2'b10);
        tick();
        exc_flush = 1'b1; dcache_busy = 1'b1;
        push(2, W_ALL, 6'b100000, F_ALL, F_ALL, 1'b0, 1'b1, 2'b00, 2'b00);
        tick();
        exc_flush = 1'b0; dcache_busy = 1'b0;
        expect_all(2, W_DIV, F_EXMM, 1'b1, 2'b10);
        tick();

        // Reset mid-divide, then IDLE after release.
        do_reset();
        exe_is_div = 1'b1;
        tick();
        tick();
        rst = 1'b1;
        expect_all(2, W_NONE, F_ALL, 1'b0, 2'b00);
        tick();
        rst = 1'b0; exe_is_div = 1'b0;
        expect_all(2, W_ALL, F_NONE, 1'b0, 2'b00);
        tick();
        exe_is_div = 1'b1;
        expect_all(2, W_DIV, F_EXMM, 1'b1, 2'b10);
        tick();

        tick();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
